hdmi_i2c_init: RTL and testbench
================================

HDMI_I2C_INIT -- requirements
Module: hdmi_i2c_init

Interface
REQ-001 Parameter SYSCLK_FREQUENCY, 1000, clk frequency in units of 100 kHz (1000 = 100 MHz).
REQ-002 Parameter I2C_KHZ, 100, SCL bit rate in kHz.
REQ-003 Parameter DEV_ADDR, 8'h72, 8-bit write address of the ADV7513 HDMI transmitter.
REQ-004 clk  in  1  system clock, the same clock as the video/CPU core; sole clock of the block.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to rerun the init table, e.g. on hot-plug interrupt.
REQ-007 scl_in  in  1  sampled SCL pad level.
REQ-008 sda_in  in  1  sampled SDA pad level.
REQ-009 scl_oe  out  1  1 = pull SCL low; 0 = release the line (open-drain).
REQ-010 sda_oe  out  1  1 = pull SDA low; 0 = release the line.
REQ-011 busy  out  1  high while a table run is in progress.
REQ-012 done  out  1  high after the last entry has been acknowledged; cleared when a run starts.
REQ-013 error  out  1  sticky NACK flag; cleared when a run starts.

Function
REQ-014 A quarter-bit tick SHALL fire every Q = SYSCLK_FREQUENCY*100/(4*I2C_KHZ) clk cycles (250 at defaults); all SCL/SDA changes occur only on ticks.
REQ-015 FSM states: IDLE, START, BIT, ACK, STOP, NEXT, HALT.
REQ-016 A run SHALL begin automatically one tick after reset release; start pulses while busy=1 SHALL be ignored.
REQ-017 Each table entry SHALL be sent as: START, DEV_ADDR, ACK, reg, ACK, data, ACK, STOP.
REQ-018 START: SDA falls while SCL is high; STOP: SDA rises while SCL is high.
REQ-019 Each bit SHALL last 4 ticks: SDA set while SCL low, SCL released, SCL high, SCL low; bits are sent MSB first.
REQ-020 ACK slot: SDA released; sda_in is sampled in the third quarter; 1 = NACK.
REQ-021 If scl_in is low while SCL is released, the tick counter SHALL hold (clock stretching).
REQ-022 On NACK: issue STOP, set error=1, go to HALT (busy=0, done=0).
REQ-023 After the last entry's STOP: done=1, busy=0, return to IDLE.
REQ-024 Entry index SHALL count 0..N-1 with no wrap; a new run restarts it at 0.
REQ-025 A start in IDLE or HALT SHALL begin a new run on the next tick.

Reset
REQ-026 On reset: scl_oe=0, sda_oe=0, busy=0, done=0, error=0, FSM=IDLE, index=0, tick counter=0.
REQ-027 Reset during a transfer SHALL release both lines immediately; no STOP is issued. The next run begins with a fresh START.

Configuration
REQ-028 HDMI_I2C_INIT_RETRY_EN defined: a NACK SHALL set error, wait 1024 ticks, then restart the run from index 0. Error is cleared on the next fully acknowledged run.
REQ-029 HDMI_I2C_INIT_RETRY_EN undefined: NACK handling per REQ-022 (halt until start).

Structure
REQ-030 Package hdmi_i2c_pkg SHALL hold the FSM state enum, the entry typedef {reg[7:0], data[7:0]}, INIT_LEN, and the table.
REQ-031 Table order: 0x41=0x10, 0x98=0x03, 0x9A=0xE0, 0x9C=0x30, 0x9D=0x61, 0xA2=0xA4, 0xA3=0xA4, 0xE0=0xD0, 0xF9=0x00, 0x15=0x00, 0x16=0x30, 0xAF=0x06.
REQ-032 Sub-module hdmi_init_rom SHALL map index to entry combinationally.

Verification
REQ-033 Release reset with an I2C slave model that ACKs everything -> 12 transactions; first bytes 0x72,0x41,0x10; done=1 and busy=0 after the last STOP.
REQ-034 Measure SCL at defaults -> high and low phases each 500 clk cycles (100 kHz).
REQ-035 Slave NACKs the data byte of entry 3 (0x9C) -> STOP, error=1, no further START. With the macro defined: restart at 0x41 after 1024*250 cycles.
REQ-036 Slave stretches SCL low for 3000 cycles in the ACK of entry 0 -> counter frozen; transfer completes with correct bits.
REQ-037 Assert reset mid-byte of entry 5 -> scl_oe=sda_oe=0 in the same cycle; after release, the run restarts with 0x72,0x41.
REQ-038 Pulse start while busy -> ignored; pulse start after done -> done clears and the full table is resent.

Source files
------------

// File: rtl/hdmi_i2c_pkg.sv
// Shared types and init table for the ADV7513 I2C register loader.
// Latency: n/a (types, constants and one elaboration-time helper only).
// Backpressure: n/a.
package hdmi_i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP,
        NEXT,
        HALT
    } state_t;

    // One register write: register address followed by the value.
    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } entry_t;

    localparam int INIT_LEN    = 12;
    localparam int IDX_W       = 4;
    localparam int RETRY_TICKS = 1024;

    // Minimal ADV7513 bring-up sequence, written in this order.
    localparam entry_t INIT_TABLE [INIT_LEN] = '{
        '{reg_addr: 8'h41, data: 8'h10},
        '{reg_addr: 8'h98, data: 8'h03},
        '{reg_addr: 8'h9A, data: 8'hE0},
        '{reg_addr: 8'h9C, data: 8'h30},
        '{reg_addr: 8'h9D, data: 8'h61},
        '{reg_addr: 8'hA2, data: 8'hA4},
        '{reg_addr: 8'hA3, data: 8'hA4},
        '{reg_addr: 8'hE0, data: 8'hD0},
        '{reg_addr: 8'hF9, data: 8'h00},
        '{reg_addr: 8'h15, data: 8'h00},
        '{reg_addr: 8'h16, data: 8'h30},
        '{reg_addr: 8'hAF, data: 8'h06}
    };

    // clk cycles per quarter SCL bit; clock is given in units of 100 kHz.
    function automatic int quarter_ticks(input int sysclk_100k, input int i2c_khz);
        return (sysclk_100k * 100) / (4 * i2c_khz);
    endfunction

endpackage

// File: rtl/hdmi_i2c_init_if.sv
// Pad-side and status signals of the HDMI I2C init block.
// Latency: n/a (signal bundle only).
// Backpressure: none; the slave side may stretch SCL through scl_in.
interface hdmi_i2c_init_if;
    logic start;
    logic scl_in;
    logic sda_in;
    logic scl_oe;
    logic sda_oe;
    logic busy;
    logic done;
    logic error;

    // The init controller drives the open-drain enables and status.
    modport master (
        input  start, scl_in, sda_in,
        output scl_oe, sda_oe, busy, done, error
    );

    // Pads, interrupt source and status consumer.
    modport slave (
        output start, scl_in, sda_in,
        input  scl_oe, sda_oe, busy, done, error
    );
endinterface

// File: rtl/hdmi_init_rom.sv
// Maps a table index to its register/value pair.
// Latency: combinational.
// Backpressure: none; out-of-range indices decode to all-zero.
module hdmi_init_rom
    import hdmi_i2c_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output entry_t           entry
);

    // Table lookup, guarded so the decode is total for every index value.
    always_comb begin
        entry = '0;
        if (int'(idx) < INIT_LEN) begin
            entry = INIT_TABLE[idx];
        end
    end

endmodule

// File: rtl/hdmi_i2c_init.sv
// Writes the ADV7513 init table over open-drain I2C after reset or on start.
// Latency: one run starts on the first quarter tick after reset/start; all line changes on ticks.
// Backpressure: SCL stretching by the slave freezes the quarter-tick timebase.
// Build option: HDMI_I2C_INIT_RETRY_EN -> after a NACK wait 1024 ticks and rerun from entry 0.
module hdmi_i2c_init
    import hdmi_i2c_pkg::*;
#(
    parameter int         SYSCLK_FREQUENCY = 1000,
    parameter int         I2C_KHZ          = 100,
    parameter logic [7:0] DEV_ADDR         = 8'h72
) (
    input  logic            clk,
    input  logic            reset,
    hdmi_i2c_init_if.master bus
);

    localparam int               Q        = quarter_ticks(SYSCLK_FREQUENCY, I2C_KHZ);
    localparam int               CNT_W    = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [CNT_W-1:0] Q_LAST   = CNT_W'(Q - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INIT_LEN - 1);
`ifdef HDMI_I2C_INIT_RETRY_EN
    localparam logic [9:0]       RETRY_LAST = 10'(RETRY_TICKS - 1);
`endif

    state_t           state;
    logic [1:0]       phase;      // quarter within the current bit / condition
    logic [2:0]       bit_cnt;    // bits left in the byte, MSB first
    logic [1:0]       byte_sel;   // 0 = device address, 1 = register, 2 = data
    logic [7:0]       shift;
    logic [IDX_W-1:0] idx;
    logic             nack;
    logic             start_pend; // run request waiting for the next tick
    logic             scl_oe_q;
    logic             sda_oe_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
`ifdef HDMI_I2C_INIT_RETRY_EN
    logic [9:0]       retry_cnt;
`endif

    logic [CNT_W-1:0] tick_cnt;
    logic             stretch;
    logic             tick;
    entry_t           entry;

    // A released SCL still read low means the slave is stretching the clock.
    assign stretch = !scl_oe_q && !bus.scl_in;
    assign tick    = !stretch && (tick_cnt == Q_LAST);

    hdmi_init_rom u_rom (
        .idx   (idx),
        .entry (entry)
    );

    // Quarter-bit timebase; holds its count while SCL is being stretched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (stretch) begin
            tick_cnt <= tick_cnt;
        end else if (tick_cnt == Q_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Bus sequencer: one line action per quarter tick, every output registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            bit_cnt    <= '0;
            byte_sel   <= '0;
            shift      <= '0;
            idx        <= '0;
            nack       <= 1'b0;
            start_pend <= 1'b1;   // first run launches on its own after reset
            scl_oe_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef HDMI_I2C_INIT_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            // Requests arriving mid-run are dropped, not queued.
            if (bus.start && !busy_q) begin
                start_pend <= 1'b1;
            end

            if (tick) begin
                case (state)
                    IDLE, HALT: begin
                        if (start_pend) begin
                            state      <= START;
                            phase      <= '0;
                            idx        <= '0;
                            nack       <= 1'b0;
                            start_pend <= 1'b0;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                            error_q    <= 1'b0;
                        end
`ifdef HDMI_I2C_INIT_RETRY_EN
                        else if (state == HALT) begin
                            // Automatic rerun keeps error set until a clean pass.
                            if (retry_cnt == RETRY_LAST) begin
                                state  <= START;
                                phase  <= '0;
                                idx    <= '0;
                                nack   <= 1'b0;
                                busy_q <= 1'b1;
                                done_q <= 1'b0;
                            end else begin
                                retry_cnt <= retry_cnt + 1'b1;
                            end
                        end
`endif
                    end

                    START: begin
                        // Both lines are released on entry: drop SDA, then SCL.
                        if (phase == 2'd0) begin
                            sda_oe_q <= 1'b1;
                            phase    <= 2'd1;
                        end else begin
                            scl_oe_q <= 1'b1;
                            state    <= BIT;
                            phase    <= 2'd0;
                            bit_cnt  <= 3'd7;
                            byte_sel <= 2'd0;
                            shift    <= DEV_ADDR;
                        end
                    end

                    BIT: begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0:    sda_oe_q <= ~shift[7];
                            2'd1:    scl_oe_q <= 1'b0;
                            2'd2:    ;
                            default: begin
                                scl_oe_q <= 1'b1;
                                shift    <= {shift[6:0], 1'b0};
                                if (bit_cnt == 3'd0) begin
                                    state <= ACK;
                                end else begin
                                    bit_cnt <= bit_cnt - 3'd1;
                                end
                            end
                        endcase
                    end

                    ACK: begin
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0:    sda_oe_q <= 1'b0;
                            2'd1:    scl_oe_q <= 1'b0;
                            2'd2:    nack     <= bus.sda_in;
                            default: begin
                                scl_oe_q <= 1'b1;
                                if (nack || byte_sel == 2'd2) begin
                                    state <= STOP;
                                end else begin
                                    state    <= BIT;
                                    bit_cnt  <= 3'd7;
                                    byte_sel <= byte_sel + 2'd1;
                                    shift    <= (byte_sel == 2'd0) ? entry.reg_addr : entry.data;
                                end
                            end
                        endcase
                    end

                    STOP: begin
                        // SCL is low on entry: pull SDA, release SCL, then release SDA.
                        phase <= phase + 2'd1;
                        case (phase)
                            2'd0:    sda_oe_q <= 1'b1;
                            2'd1:    scl_oe_q <= 1'b0;
                            2'd2:    sda_oe_q <= 1'b0;
                            default: state    <= NEXT;
                        endcase
                    end

                    NEXT: begin
                        if (nack) begin
                            state   <= HALT;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
`ifdef HDMI_I2C_INIT_RETRY_EN
                            retry_cnt <= '0;
`endif
                        end else if (idx == LAST_IDX) begin
                            state   <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            error_q <= 1'b0;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= START;
                            phase <= 2'd0;
                        end
                    end

                    default: begin
                        state    <= IDLE;
                        scl_oe_q <= 1'b0;
                        sda_oe_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.scl_oe = scl_oe_q;
    assign bus.sda_oe = sda_oe_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.error  = error_q;

endmodule

// File: tb/tb_hdmi_i2c_init.sv
// Bench for hdmi_i2c_init: open-drain bus, byte-decoding ACK/NACK slave, directed runs.
// Latency: fast instance uses 4-cycle quarter ticks; a default instance checks 100 kHz SCL timing.
// Backpressure: slave can stretch SCL once in the first transaction.
module tb_hdmi_i2c_init;

    localparam int Q  = 4;    // 1000*100/(4*6250)
    localparam int QD = 250;  // defaults

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hdmi_i2c_init_if fif ();
    hdmi_i2c_init_if dif ();

    hdmi_i2c_init #(.SYSCLK_FREQUENCY(1000), .I2C_KHZ(6250), .DEV_ADDR(8'h72)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (fif.master)
    );

    hdmi_i2c_init dut_def (
        .clk   (clk),
        .reset (rst),
        .bus   (dif.master)
    );

    logic slv_sda_low = 1'b0;
    logic slv_scl_low = 1'b0;
    assign fif.scl_in = ~(fif.scl_oe | slv_scl_low);
    assign fif.sda_in = ~(fif.sda_oe | slv_sda_low);
    assign dif.scl_in = ~dif.scl_oe;
    assign dif.sda_in = ~dif.sda_oe;
    assign dif.start  = 1'b0;

    logic [7:0] exp_tab [24] = '{
        8'h41, 8'h10, 8'h98, 8'h03, 8'h9A, 8'hE0, 8'h9C, 8'h30,
        8'h9D, 8'h61, 8'hA2, 8'hA4, 8'hA3, 8'hA4, 8'hE0, 8'hD0,
        8'hF9, 8'h00, 8'h15, 8'h00, 8'h16, 8'h30, 8'hAF, 8'h06
    };

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave-model controls, written only by the stimulus process.
    logic       nack_en    = 1'b0;
    logic [7:0] nack_reg   = 8'h00;
    logic       stretch_en = 1'b0;

    // Slave-model state, written only by the slave process.
    int         start_cnt = 0;
    int         stop_cnt  = 0;
    int         bit_cnt   = 0;
    int         byte_idx  = 0;
    int         hold_left = 0;
    int         st_fall   = 0;
    int         st_rel    = 0;
    int         st_high   = 0;
    logic       in_xfer   = 1'b0;
    logic       ack_phase = 1'b0;
    logic       scl_p     = 1'b1;
    logic       sda_p     = 1'b1;
    logic [7:0] sh        = 8'h00;
    logic [7:0] cur_reg   = 8'h00;
    logic [7:0] byte_q [$];

    // I2C slave: decodes START/STOP and bytes, ACKs (or NACKs), optional stretch.
    always @(negedge clk) begin
        logic scl_now, sda_now;
        scl_now = fif.scl_in;
        sda_now = fif.sda_in;
        if (rst) begin
            start_cnt = 0; stop_cnt = 0; bit_cnt = 0; byte_idx = 0; hold_left = 0;
            in_xfer = 1'b0; ack_phase = 1'b0; slv_sda_low = 1'b0; slv_scl_low = 1'b0;
            scl_p = 1'b1; sda_p = 1'b1;
            byte_q.delete();
        end else begin
            if (scl_now && scl_p && sda_p && !sda_now) begin
                start_cnt++; in_xfer = 1'b1; bit_cnt = 0; byte_idx = 0; ack_phase = 1'b0;
            end else if (scl_now && scl_p && !sda_p && sda_now) begin
                stop_cnt++; in_xfer = 1'b0; slv_sda_low = 1'b0; ack_phase = 1'b0;
            end else if (in_xfer && scl_now && !scl_p) begin
                if (!ack_phase && bit_cnt < 8) begin
                    sh = {sh[6:0], sda_now};
                    bit_cnt++;
                end
            end else if (in_xfer && !scl_now && scl_p) begin
                if (st_rel != 0 && st_high == 0) st_high = cyc - st_rel;
                if (ack_phase) begin
                    slv_sda_low = 1'b0; ack_phase = 1'b0; bit_cnt = 0; byte_idx++;
                end else if (bit_cnt == 8) begin
                    byte_q.push_back(sh);
                    if (byte_idx == 1) cur_reg = sh;
                    ack_phase   = 1'b1;
                    slv_sda_low = !(nack_en && byte_idx == 2 && cur_reg == nack_reg);
                    if (stretch_en && start_cnt == 1 && byte_idx == 0) begin
                        slv_scl_low = 1'b1; hold_left = 3000; st_fall = cyc;
                    end
                end
            end
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) begin
                    slv_scl_low = 1'b0; st_rel = cyc;
                end
            end
            scl_p = scl_now;
            sda_p = sda_now;
        end
    end

    // SCL edge times of the default-rate instance (first low, high phases).
    int   d_fall1 = -1, d_rise1 = -1, d_fall2 = -1;
    logic d_scl_p = 1'b1;
    always @(negedge clk) begin
        if (!rst) begin
            if (d_scl_p && !dif.scl_in) begin
                if (d_fall1 < 0) d_fall1 = cyc;
                else if (d_rise1 >= 0 && d_fall2 < 0) d_fall2 = cyc;
            end
            if (!d_scl_p && dif.scl_in && d_fall1 >= 0 && d_rise1 < 0) d_rise1 = cyc;
            d_scl_p = dif.scl_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_run(input string tag, input int b_base, input int s_base, input int p_base);
        check({tag, "_starts"}, start_cnt - s_base, 32'd12);
        check({tag, "_stops"},  stop_cnt - p_base,  32'd12);
        check({tag, "_nbytes"}, byte_q.size() - b_base, 32'd36);
        if (byte_q.size() - b_base >= 36) begin
            for (int t = 0; t < 12; t++) begin
                check($sformatf("%s_addr%0d", tag, t), 32'(byte_q[b_base + 3*t]),     32'h72);
                check($sformatf("%s_reg%0d",  tag, t), 32'(byte_q[b_base + 3*t + 1]), 32'(exp_tab[2*t]));
                check($sformatf("%s_data%0d", tag, t), 32'(byte_q[b_base + 3*t + 2]), 32'(exp_tab[2*t + 1]));
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        fif.start = 1'b1;
        @(negedge clk);
        fif.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 20000 && !fif.done; i++) @(negedge clk);
        check({tag, "_done"}, 32'(fif.done), 32'd1);
        check({tag, "_busy"}, 32'(fif.busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required end of test");
        $fatal(1);
    end

    initial begin
        int b0, s0, p0, e_cyc;
        rst = 1'b1;
        fif.start = 1'b0;
        stretch_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_scl_oe", 32'(fif.scl_oe), 32'd0);
        check("rst_sda_oe", 32'(fif.sda_oe), 32'd0);
        check("rst_busy",   32'(fif.busy),   32'd0);
        check("rst_done",   32'(fif.done),   32'd0);
        check("rst_error",  32'(fif.error),  32'd0);

        // Run 1: automatic after reset, slave stretches the first ACK.
        rst = 1'b0;
        repeat (Q - 1) @(posedge clk);
        #1 check("busy_before_tick", 32'(fif.busy), 32'd0);
        @(posedge clk);
        #1 check("busy_first_tick", 32'(fif.busy), 32'd1);
        wait_done("run1");
        check("run1_error", 32'(fif.error), 32'd0);
        check_run("run1", 0, 0, 0);
        check("stretch_low_len", 32'(st_rel - st_fall >= 2990), 32'd1);
        check("stretch_high_len", st_high, 32'(2 * Q));
        stretch_en = 1'b0;

        // Start after done reruns the table; start while busy is ignored.
        b0 = byte_q.size(); s0 = start_cnt; p0 = stop_cnt;
        pulse_start();
        repeat (Q + 1) @(negedge clk);
        check("rerun_busy", 32'(fif.busy), 32'd1);
        check("rerun_done_clr", 32'(fif.done), 32'd0);
        repeat (300) @(negedge clk);
        check("midrun_busy", 32'(fif.busy), 32'd1);
        pulse_start();
        wait_done("rerun");
        check_run("rerun", b0, s0, p0);
        repeat (200) @(negedge clk);
        check("ignored_start_busy", 32'(fif.busy), 32'd0);
        check("ignored_start_cnt", start_cnt - s0, 32'd12);

        // NACK on the data byte of entry 3 (register 0x9C).
        b0 = byte_q.size(); s0 = start_cnt; p0 = stop_cnt;
        nack_en = 1'b1; nack_reg = 8'h9C;
        pulse_start();
        for (int i = 0; i < 20000 && !fif.error; i++) @(negedge clk);
        e_cyc = cyc;
        check("nack_error", 32'(fif.error), 32'd1);
        check("nack_busy",  32'(fif.busy),  32'd0);
        check("nack_done",  32'(fif.done),  32'd0);
        check("nack_starts", start_cnt - s0, 32'd4);
        check("nack_stops",  stop_cnt - p0,  32'd4);
        check("nack_nbytes", byte_q.size() - b0, 32'd12);
        if (byte_q.size() - b0 >= 12) check("nack_last_byte", 32'(byte_q[b0 + 11]), 32'h30);
`ifdef HDMI_I2C_INIT_RETRY_EN
        for (int i = 0; i < 1024 * Q + 200 && (start_cnt - s0) < 5; i++) @(negedge clk);
        check("retry_restart", start_cnt - s0, 32'd5);
        check("retry_delay", 32'((cyc - e_cyc) >= 1024 * Q && (cyc - e_cyc) <= 1026 * Q), 32'd1);
        nack_en = 1'b0;
        check("retry_err_held", 32'(fif.error), 32'd1);
        wait_done("retry");
        check("retry_err_clr", 32'(fif.error), 32'd0);
        if (byte_q.size() - b0 >= 14) begin
            check("retry_b0", 32'(byte_q[b0 + 12]), 32'h72);
            check("retry_b1", 32'(byte_q[b0 + 13]), 32'h41);
        end
`else
        repeat (1200) @(negedge clk);
        check("halt_no_start", start_cnt - s0, 32'd4);
        check("halt_busy", 32'(fif.busy), 32'd0);
        check("halt_error", 32'(fif.error), 32'd1);
        nack_en = 1'b0;
        b0 = byte_q.size(); s0 = start_cnt; p0 = stop_cnt;
        pulse_start();
        repeat (Q + 1) @(negedge clk);
        check("halt_restart_err_clr", 32'(fif.error), 32'd0);
        check("halt_restart_busy", 32'(fif.busy), 32'd1);
        wait_done("halt_rerun");
        check_run("halt_rerun", b0, s0, p0);
`endif

        // Reset in the middle of entry 5 releases both lines at once.
        b0 = byte_q.size();
        pulse_start();
        for (int i = 0; i < 20000 && byte_q.size() < b0 + 16; i++) @(negedge clk);
        for (int i = 0; i < 200 && !(fif.scl_oe && fif.sda_oe); i++) @(negedge clk);
        check("pre_reset_lines", 32'(fif.scl_oe && fif.sda_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("reset_scl_rel", 32'(fif.scl_oe), 32'd0);
        check("reset_sda_rel", 32'(fif.sda_oe), 32'd0);
        check("reset_busy",    32'(fif.busy),   32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_done("post_reset");
        check_run("post_reset", 0, 0, 0);

        // SCL phases of the default 100 MHz / 100 kHz instance.
        check("dflt_scl_low",  32'(d_rise1 - d_fall1), 32'(2 * QD));
        check("dflt_scl_high", 32'(d_fall2 - d_rise1), 32'(2 * QD));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
